// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl
// Self-test sequencer for the LFSR-fed adder datapath (two LFSR pattern sources feeding an
// adder). A run loads both LFSR seeds, steps through a programmable number of vectors and
// folds each {carry, sum} result into a MISR. The final signature is compared with a golden
// value to give a pass/fail result.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          request a run (sampled only while idle)
//   num_vec        vectors per run, latched on start
//   seed_a_cfg     LFSR A seed, latched on start
//   seed_b_cfg     LFSR B seed, latched on start
//   cin_cfg        adder carry-in, latched on start
//   expected_sig   golden signature, latched on start
//   sum_in         adder sum from the datapath
//   cout_in        adder carry-out from the datapath
//   seed_a         latched LFSR A seed
//   seed_b         latched LFSR B seed
//   adder_cin      latched adder carry-in
//   lfsr_load      load seeds into the LFSRs (one cycle)
//   lfsr_en        advance the LFSRs one step
//   busy           run in progress
//   done           one-cycle pulse at the end of a run
//   pass           signature matched; valid from done, held until the next start
//   signature      current MISR value, held after the run
//   vec_count      vectors compacted so far
module adder_bist_ctrl #(
    parameter int unsigned      WIDTH = 12,
    parameter int unsigned      CNT_W = 8,
    parameter int unsigned      SIG_W = WIDTH + 1,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(13'h001B)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [WIDTH-1:0] seed_a_cfg,
    input  logic [WIDTH-1:0] seed_b_cfg,
    input  logic             cin_cfg,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] seed_a,
    output logic [WIDTH-1:0] seed_b,
    output logic             adder_cin,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] num_vec_q,   num_vec_d;
    logic [WIDTH-1:0] seed_a_q,    seed_a_d;
    logic [WIDTH-1:0] seed_b_q,    seed_b_d;
    logic             cin_q,       cin_d;
    logic [SIG_W-1:0] exp_sig_q,   exp_sig_d;
    logic [SIG_W-1:0] sig_q,       sig_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic             pass_q,      pass_d;

    logic [SIG_W-1:0] d_vec;
    logic [SIG_W-1:0] misr_next;
    logic [CNT_W-1:0] vec_count_inc;
    logic             sig_match;

    assign d_vec         = SIG_W'({cout_in, sum_in});
    // Galois MISR: shift left, fold the dropped MSB back through POLY, then absorb the vector.
    assign misr_next     = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ d_vec;
    assign vec_count_inc = vec_count_q + CNT_W'(1);
    assign sig_match     = (sig_q == exp_sig_q);

    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        seed_a_d    = seed_a_q;
        seed_b_d    = seed_b_q;
        cin_d       = cin_q;
        exp_sig_d   = exp_sig_q;
        sig_d       = sig_q;
        vec_count_d = vec_count_q;
        pass_d      = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_vec_d   = num_vec;
                    seed_a_d    = seed_a_cfg;
                    seed_b_d    = seed_b_cfg;
                    cin_d       = cin_cfg;
                    exp_sig_d   = expected_sig;
                    sig_d       = '0;
                    vec_count_d = '0;
                    pass_d      = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (num_vec_q == '0) ? ST_CHECK : ST_RUN;
            end
            ST_RUN: begin
                sig_d       = misr_next;
                vec_count_d = vec_count_inc;
                if (vec_count_inc == num_vec_q) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pass_d  = sig_match;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_vec_q   <= '0;
            seed_a_q    <= '0;
            seed_b_q    <= '0;
            cin_q       <= 1'b0;
            exp_sig_q   <= '0;
            sig_q       <= '0;
            vec_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            seed_a_q    <= seed_a_d;
            seed_b_q    <= seed_b_d;
            cin_q       <= cin_d;
            exp_sig_q   <= exp_sig_d;
            sig_q       <= sig_d;
            vec_count_q <= vec_count_d;
            pass_q      <= pass_d;
        end
    end

    // Control strobes decode straight from state so a reset drops them on the same edge.
    assign lfsr_load = (state_q == ST_LOAD);
    assign lfsr_en   = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_CHECK);
    // Pass is live during the done cycle, then held in pass_q.
    assign pass      = (state_q == ST_CHECK) ? sig_match : pass_q;

    assign seed_a    = seed_a_q;
    assign seed_b    = seed_b_q;
    assign adder_cin = cin_q;
    assign signature = sig_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
module tb_adder_bist_ctrl;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SIG_W = 13;
    localparam logic [SIG_W-1:0] POLY = 13'h001B;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic [WIDTH-1:0] seed_a_cfg;
    logic [WIDTH-1:0] seed_b_cfg;
    logic             cin_cfg;
    logic [SIG_W-1:0] expected_sig;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic [WIDTH-1:0] seed_a;
    logic [WIDTH-1:0] seed_b;
    logic             adder_cin;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] vec_count;

    int errors = 0;
    int checks = 0;

    adder_bist_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_vec      (num_vec),
        .seed_a_cfg   (seed_a_cfg),
        .seed_b_cfg   (seed_b_cfg),
        .cin_cfg      (cin_cfg),
        .expected_sig (expected_sig),
        .sum_in       (sum_in),
        .cout_in      (cout_in),
        .seed_a       (seed_a),
        .seed_b       (seed_b),
        .adder_cin    (adder_cin),
        .lfsr_load    (lfsr_load),
        .lfsr_en      (lfsr_en),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .vec_count    (vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] nv;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic             cin;
        logic [SIG_W-1:0] exp_sig;
        logic [SIG_W-1:0] d0;
        logic [SIG_W-1:0] d1;
        logic [SIG_W-1:0] want_sig;
        logic             want_pass;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] d);
        logic [SIG_W-1:0] r;
        r = {s[SIG_W-2:0], 1'b0};
        if (s[SIG_W-1]) r = r ^ POLY;
        return r ^ d;
    endfunction

    function automatic logic [SIG_W-1:0] long_d(input int k);
        return SIG_W'(k * 37 + 5);
    endfunction

    task automatic drive_d(input logic [SIG_W-1:0] d);
        {cout_in, sum_in} = d;
    endtask

    // Short run (0..2 vectors) from the table; start is re-pulsed with junk config in LOAD.
    task automatic run_entry(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        num_vec      = v.nv;
        seed_a_cfg   = v.sa;
        seed_b_cfg   = v.sb;
        cin_cfg      = v.cin;
        expected_sig = v.exp_sig;
        start        = 1'b1;
        tick();
        check({tag, " lfsr_load"}, 32'(lfsr_load), 32'd1);
        check({tag, " load busy"}, 32'(busy), 32'd1);
        check({tag, " load en"}, 32'(lfsr_en), 32'd0);
        check({tag, " seed_a"}, 32'(seed_a), 32'(v.sa));
        check({tag, " seed_b"}, 32'(seed_b), 32'(v.sb));
        check({tag, " cin"}, 32'(adder_cin), 32'(v.cin));
        check({tag, " load sig"}, 32'(signature), 32'd0);
        check({tag, " load pass"}, 32'(pass), 32'd0);
        seed_a_cfg   = ~v.sa;
        seed_b_cfg   = ~v.sb;
        cin_cfg      = ~v.cin;
        num_vec      = 8'hFF;
        expected_sig = ~v.exp_sig;
        for (int k = 0; k < int'(v.nv); k++) begin
            tick();
            start = 1'b0;
            check({tag, " run en"}, 32'(lfsr_en), 32'd1);
            check({tag, " run cnt"}, 32'(vec_count), 32'(k));
            drive_d((k == 0) ? v.d0 : v.d1);
        end
        tick();
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " en at done"}, 32'(lfsr_en), 32'd0);
        check({tag, " signature"}, 32'(signature), 32'(v.want_sig));
        check({tag, " pass"}, 32'(pass), 32'(v.want_pass));
        check({tag, " vec_count"}, 32'(vec_count), 32'(v.nv));
        check({tag, " seed_a kept"}, 32'(seed_a), 32'(v.sa));
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " pass held"}, 32'(pass), 32'(v.want_pass));
        check({tag, " sig held"}, 32'(signature), 32'(v.want_sig));
    endtask

    initial begin
        logic [SIG_W-1:0] model;
        int cyc;
        int busy_cnt;
        int k;
        int done_seen;
        int load_seen;

        tbl[0] = '{nv: 8'd1, sa: 12'h001, sb: 12'h009, cin: 1'b0, exp_sig: 13'h000A,
                   d0: 13'h000A, d1: 13'h0000, want_sig: 13'h000A, want_pass: 1'b1};
        tbl[1] = '{nv: 8'd2, sa: 12'h123, sb: 12'h456, cin: 1'b1, exp_sig: 13'h0000,
                   d0: 13'h0001, d1: 13'h0002, want_sig: 13'h0000, want_pass: 1'b1};
        tbl[2] = '{nv: 8'd2, sa: 12'hFFF, sb: 12'h001, cin: 1'b0, exp_sig: 13'h001B,
                   d0: 13'h1000, d1: 13'h0000, want_sig: 13'h001B, want_pass: 1'b1};
        tbl[3] = '{nv: 8'd1, sa: 12'hABC, sb: 12'h321, cin: 1'b1, exp_sig: 13'h1FFE,
                   d0: 13'h1FFF, d1: 13'h0000, want_sig: 13'h1FFF, want_pass: 1'b0};
        tbl[4] = '{nv: 8'd0, sa: 12'h055, sb: 12'h0AA, cin: 1'b0, exp_sig: 13'h0000,
                   d0: 13'h1234, d1: 13'h0000, want_sig: 13'h0000, want_pass: 1'b1};
        tbl[5] = '{nv: 8'd0, sa: 12'h777, sb: 12'h888, cin: 1'b1, exp_sig: 13'h0005,
                   d0: 13'h0000, d1: 13'h0000, want_sig: 13'h0000, want_pass: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        num_vec = '0;
        seed_a_cfg = '0;
        seed_b_cfg = '0;
        cin_cfg = 1'b0;
        expected_sig = '0;
        sum_in = '0;
        cout_in = 1'b0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst load", 32'(lfsr_load), 32'd0);
        check("rst en", 32'(lfsr_en), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst sig", 32'(signature), 32'd0);
        check("rst seed_a", 32'(seed_a), 32'd0);
        check("rst vec_count", 32'(vec_count), 32'd0);
        reset = 1'b0;
        tick();
        check("idle no start", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_entry(i, tbl[i]);
        end

        // Long run: 100 vectors, golden off by one bit.
        model = '0;
        for (int j = 0; j < 100; j++) model = misr(model, long_d(j));
        num_vec      = 8'd100;
        seed_a_cfg   = 12'h3C3;
        seed_b_cfg   = 12'h0F0;
        cin_cfg      = 1'b0;
        expected_sig = model ^ 13'h0001;
        start        = 1'b1;
        tick();
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        cyc      = 0;
        k        = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
            if (lfsr_en) begin
                drive_d(long_d(k));
                k++;
            end
        end
        check("long done latency", 32'(cyc), 32'd101);
        check("long busy cycles", 32'(busy_cnt), 32'd102);
        check("long done", 32'(done), 32'd1);
        check("long vec_count", 32'(vec_count), 32'd100);
        check("long signature", 32'(signature), 32'(model));
        check("long pass", 32'(pass), 32'd0);
        tick();
        check("long pass held", 32'(pass), 32'd0);

        // Reset in the middle of a run.
        num_vec      = 8'd200;
        seed_a_cfg   = 12'h111;
        expected_sig = '0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 41; j++) begin
            tick();
            drive_d(SIG_W'(j + 1));
        end
        check("mid vec_count", 32'(vec_count), 32'd40);
        check("mid en", 32'(lfsr_en), 32'd1);
        reset = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort en", 32'(lfsr_en), 32'd0);
        check("abort sig", 32'(signature), 32'd0);
        check("abort vec_count", 32'(vec_count), 32'd0);
        check("abort seed_a", 32'(seed_a), 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 6; j++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort no done", 32'(done_seen), 32'd0);

        // Start held across done: a second run follows with freshly latched config.
        num_vec      = 8'd1;
        seed_a_cfg   = 12'h00A;
        expected_sig = 13'h0003;
        start        = 1'b1;
        tick();
        num_vec      = 8'd0;
        seed_a_cfg   = 12'h5A5;
        expected_sig = 13'h0000;
        tick();
        drive_d(13'h0003);
        check("b2b seed_a run1", 32'(seed_a), 32'h00A);
        tick();
        check("b2b done1", 32'(done), 32'd1);
        check("b2b sig1", 32'(signature), 32'h0003);
        check("b2b pass1", 32'(pass), 32'd1);
        load_seen = 0;
        for (int j = 0; j < 2 && load_seen == 0; j++) begin
            tick();
            if (lfsr_load) load_seen = 1;
        end
        start = 1'b0;
        check("b2b reload", 32'(load_seen), 32'd1);
        check("b2b seed_a run2", 32'(seed_a), 32'h5A5);
        check("b2b pass cleared", 32'(pass), 32'd0);
        done_seen = 0;
        for (int j = 0; j < 3 && done_seen == 0; j++) begin
            tick();
            if (done) done_seen = 1;
        end
        check("b2b done2", 32'(done_seen), 32'd1);
        check("b2b sig2", 32'(signature), 32'd0);
        check("b2b pass2", 32'(pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
